// File: rtl/uart_transmitter.sv
// UART transmitter with a small TX holding FIFO: 8N1 frames, LSB first,
// bit timing driven by an external oversample tick (s_tick).
module uart_transmitter #(
   parameter int OVERSAMPLE_RATE = 16,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic       tx_enabled,
   input  logic       s_tick,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       tx
);

   localparam int               PTR_W    = $clog2(FIFO_DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [3:0]       S_LAST   = 4'(OVERSAMPLE_RATE - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   // ------------------------------------------------------------------
   // TX holding FIFO
   // ------------------------------------------------------------------
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   // full is taken from the registered count, so a pop in the same cycle
   // never makes room for a write that arrives while full.
   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);
   assign push  = wr_en && !full;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
         err <= wr_en && full;
      end
   end

   // NOTE: the storage array is deliberately not reset; the count and
   // pointers define which entries are valid, so clearing data is wasted logic.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t     state,     state_nxt;
   logic [3:0] s_cnt,     s_cnt_nxt;
   logic [2:0] bit_cnt,   bit_cnt_nxt;
   logic [7:0] shift_reg, shift_nxt;
   logic       tx_nxt;
   logic       done_nxt;

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state     <= IDLE;
         s_cnt     <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         s_cnt     <= s_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift_reg <= shift_nxt;
         tx        <= tx_nxt;
         done      <= done_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt   = state;
      s_cnt_nxt   = s_cnt;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift_reg;
      tx_nxt      = tx;
      done_nxt    = 1'b0;
      pop         = 1'b0;

      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (tx_enabled && !empty) begin
               pop       = 1'b1;
               shift_nxt = mem[rd_ptr];
               s_cnt_nxt = '0;
               state_nxt = START;
               tx_nxt    = 1'b0;
            end
         end

         START: begin
            if (s_tick) begin
               if (s_cnt == S_LAST) begin
                  s_cnt_nxt   = '0;
                  bit_cnt_nxt = '0;
                  state_nxt   = DATA;
                  tx_nxt      = shift_reg[0];
               end else begin
                  s_cnt_nxt = s_cnt + 1'b1;
               end
            end
         end

         DATA: begin
            if (s_tick) begin
               if (s_cnt == S_LAST) begin
                  s_cnt_nxt = '0;
                  if (bit_cnt == 3'd7) begin
                     state_nxt = STOP;
                     tx_nxt    = 1'b1;
                  end else begin
                     // shift_reg[1] becomes the new LSB on the line
                     shift_nxt   = {1'b0, shift_reg[7:1]};
                     bit_cnt_nxt = bit_cnt + 1'b1;
                     tx_nxt      = shift_reg[1];
                  end
               end else begin
                  s_cnt_nxt = s_cnt + 1'b1;
               end
            end
         end

         STOP: begin
            if (s_tick) begin
               if (s_cnt == S_LAST) begin
                  s_cnt_nxt = '0;
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
                  tx_nxt    = 1'b1;
               end else begin
                  s_cnt_nxt = s_cnt + 1'b1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter (OVERSAMPLE_RATE=16,
// FIFO_DEPTH=4): frame shape/timing, FIFO full/err, enable gating, reset.
module tb_uart_transmitter;

   logic       clk = 1'b0;
   logic       rstN;
   logic       tx_enabled;
   logic       s_tick;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic       busy;
   logic       done;
   logic       err;
   logic       tx;

   int n_checks = 0;
   int n_pass   = 0;
   int tick_div = 1;
   int tick_ph  = 0;

   uart_transmitter #(
      .OVERSAMPLE_RATE(16),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk       (clk),
      .rstN      (rstN),
      .tx_enabled(tx_enabled),
      .s_tick    (s_tick),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .tx        (tx)
   );

   always #5 clk = ~clk;

   // s_tick pulses once every tick_div cycles (tick_div=0 disables it)
   initial begin
      s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_div == 0) begin
            s_tick = 1'b0;
         end else begin
            tick_ph = (tick_ph + 1) % tick_div;
            s_tick  = (tick_ph == 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic wait_fall(input int budget, input string tag, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (tx === 1'b0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      check(tag, ok, 1);
   endtask

   task automatic hold_idle(input int n, input string tag);
      bit moved = 1'b0;
      repeat (n) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) moved = 1'b1;
      end
      check(tag, moved, 0);
   endtask

   // Follows one frame from its start bit to the done pulse. t=0 is the first
   // cycle with tx low; bit k is sampled at its midpoint k*bc + bc/2.
   task automatic watch_frame(input logic [7:0] exp, input int div, input int drop_at,
                              input string tag);
      int         bc;
      int         t;
      logic [9:0] line;
      logic [9:0] exp_line;
      bit         seen_done;
      bit         edges_ok;
      bit         busy_ok;
      bit         ok;
      bc        = 16 * div;
      exp_line  = {1'b1, exp, 1'b0};
      line      = '1;
      seen_done = 1'b0;
      edges_ok  = 1'b1;
      busy_ok   = 1'b1;
      t         = 0;
      wait_fall(20 * bc, {tag, ":start"}, ok);
      if (!ok) return;
      while (!seen_done && t <= 11 * bc) begin
         if (t == drop_at) tx_enabled = 1'b0;
         for (int k = 0; k < 10; k++)
            if (t == k * bc + bc / 2) line[k] = tx;
         if (div == 1 && t < 10 * bc && tx !== exp_line[t / 16]) edges_ok = 1'b0;
         if (done === 1'b1) begin
            seen_done = 1'b1;
         end else begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
            t++;
         end
      end
      check({tag, ":done"}, seen_done, 1);
      check({tag, ":line"}, line, exp_line);
      check({tag, ":busy"}, busy_ok, 1);
      check({tag, ":busy_after"}, busy, 0);
      check({tag, ":len"}, (t >= 10 * bc - (div - 1)) && (t <= 10 * bc), 1);
      if (div == 1) check({tag, ":edges"}, edges_ok, 1);
   endtask

   logic [7:0] q_bytes [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
   logic [7:0] f_bytes [4] = '{8'h81, 8'h42, 8'h24, 8'h18};

   initial begin
      rstN       = 1'b0;
      tx_enabled = 1'b0;
      wr_en      = 1'b0;
      wr_data    = '0;
      tick_div   = 1;
      repeat (3) step();
      check("rst_tx",    tx,    1);
      check("rst_busy",  busy,  0);
      check("rst_done",  done,  0);
      check("rst_err",   err,   0);
      check("rst_full",  full,  0);
      check("rst_empty", empty, 1);
      rstN = 1'b1;
      step();

      // Single 0x55 frame, s_tick every cycle: 16 cycles per bit, 160 busy
      tx_enabled = 1'b1;
      push(8'h55);
      check("nobypass_tx", tx,    1);
      check("wr_empty",    empty, 0);
      step();
      check("fall_tx",     tx,    0);
      check("fall_busy",   busy,  1);
      watch_frame(8'h55, 1, -1, "f55");
      check("f55_empty",   empty, 1);
      step();
      check("done_1cyc",   done,  0);

      // Fill FIFO while disabled, overflow on the fifth write, then drain
      tx_enabled = 1'b0;
      for (int i = 0; i < 4; i++) push(q_bytes[i]);
      check("q_full",   full, 1);
      push(q_bytes[4]);
      check("q_err",    err,  1);
      check("q_full2",  full, 1);
      step();
      check("q_err_1cyc", err, 0);
      check("q_tx_idle",  tx,  1);
      check("q_busy",     busy, 0);
      tx_enabled = 1'b1;
      for (int i = 0; i < 4; i++) watch_frame(q_bytes[i], 1, -1, $sformatf("q%0d", i));
      check("q_empty", empty, 1);

      // s_tick every 3rd cycle: 48 cycles per bit, back-to-back 0x00 and 0xFF
      tick_div = 3;
      push(8'h00);
      push(8'hFF);
      watch_frame(8'h00, 3, -1, "f00");
      watch_frame(8'hFF, 3, -1, "fff");
      tick_div = 1;

      // Disable during data bit 3 of 0x3C; 0x5A must wait for re-enable
      push(8'h3C);
      push(8'h5A);
      watch_frame(8'h3C, 1, 72, "f3c");
      hold_idle(40, "dis_hold");
      check("dis_queued", empty, 0);
      tx_enabled = 1'b1;
      watch_frame(8'h5A, 1, -1, "f5a");
      check("dis_empty", empty, 1);

      // Reset during data bit 5 with two bytes queued
      push(8'h11);
      push(8'h22);
      push(8'h33);
      repeat (100) step();
      rstN = 1'b0;
      step();
      check("mrst_tx",    tx,    1);
      check("mrst_busy",  busy,  0);
      check("mrst_empty", empty, 1);
      check("mrst_full",  full,  0);
      rstN = 1'b1;
      hold_idle(300, "mrst_quiet");
      check("mrst_empty2", empty, 1);

      // Write while full in the same cycle as a pop: write dropped, count 3
      tx_enabled = 1'b0;
      for (int i = 0; i < 4; i++) push(f_bytes[i]);
      check("fp_full", full, 1);
      tx_enabled = 1'b1;
      wr_en      = 1'b1;
      wr_data    = 8'hEE;
      step();
      wr_en      = 1'b0;
      check("fp_err",   err,   1);
      check("fp_full2", full,  0);
      check("fp_busy",  busy,  1);
      for (int i = 0; i < 4; i++) watch_frame(f_bytes[i], 1, -1, $sformatf("fp%0d", i));
      check("fp_empty", empty, 1);
      hold_idle(40, "fp_quiet");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
